// File: rtl/seq_divider_pkg.sv
// Shared encodings for the multi-cycle restoring divider.
// Op codes follow RV32M funct3[1:0].
package seq_divider_pkg;
  localparam int DEF_WIDTH = 32;

  typedef logic [1:0] op_t;

  localparam op_t OP_DIV  = 2'b00;
  localparam op_t OP_DIVU = 2'b01;
  localparam op_t OP_REM  = 2'b10;
  localparam op_t OP_REMU = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic op_signed(op_t op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(op_t op);
    return op[1];
  endfunction
endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle between EX and the divider.
// The core is master; the divider is slave.
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic             flush;
  op_t              op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, flush, op, dividend, divisor,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, op, dividend, divisor,
    output busy, done, result
  );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring step: subtract divisor from the shifted
// partial remainder on WIDTH+1 bits, restore on borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_msb,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);
  logic [WIDTH+1:0] w_diff;
  logic             w_unused_top;

  assign w_diff = {1'b0, i_rem, i_msb} - {2'b00, i_dvs};
  assign o_qbit = ~w_diff[WIDTH+1];

  // A kept difference is below the divisor, so bit WIDTH is zero.
  assign w_unused_top = w_diff[WIDTH];

  assign o_rem = o_qbit ? w_diff[WIDTH-1:0]
                        : {i_rem[WIDTH-2:0], i_msb};
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle, fixed latency WIDTH+1.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic         clk,
  input logic         rst,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_is_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_pend;
  logic [WIDTH-1:0] r_result;

  logic             w_accept;
  logic             w_sgn;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_rem_nx;
  logic             w_qbit;
  logic [WIDTH-1:0] w_quo_nx;
  logic             w_last;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH-1:0] w_fix;

  assign w_accept = (r_state == S_IDLE) & bus.start
                  & ~bus.flush;
  assign w_sgn    = op_signed(bus.op);
  assign w_neg_a  = w_sgn & bus.dividend[WIDTH-1];
  assign w_neg_b  = w_sgn & bus.divisor[WIDTH-1];
  assign w_abs_a  = w_neg_a ? -bus.dividend : bus.dividend;
  assign w_abs_b  = w_neg_b ? -bus.divisor : bus.divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_msb  (r_quo[WIDTH-1]),
    .i_dvs  (r_dvs),
    .o_rem  (w_rem_nx),
    .o_qbit (w_qbit)
  );

  assign w_quo_nx = {r_quo[WIDTH-2:0], w_qbit};
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // Zero divisor: remainder re-signs to the original dividend.
  always_comb begin
    w_q_fix = r_neg_q ? -w_quo_nx : w_quo_nx;
    if (r_dz) w_q_fix = '1;
    w_r_fix = r_neg_r ? -w_rem_nx : w_rem_nx;
    w_fix   = r_is_rem ? w_r_fix : w_q_fix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_pend   <= '0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state  <= S_CALC;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= w_abs_a;
            r_dvs    <= w_abs_b;
            r_is_rem <= op_is_rem(bus.op);
            r_neg_q  <= w_neg_a ^ w_neg_b;
            r_neg_r  <= w_neg_a;
            r_dz     <= (bus.divisor == '0);
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            if (w_last) begin
              r_pend  <= w_fix;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          if (!bus.flush) r_result <= r_pend;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A flush in the DONE cycle hides the pending result.
  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = (r_state == S_DONE) & ~bus.flush;
  assign bus.result = bus.done ? r_pend : r_result;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at WIDTH=32.
// Checks latency, results, busy/flush/reset behaviour.
module tb_seq_divider;
  import seq_divider_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  seq_divider_if #(.WIDTH(32)) bus ();

  seq_divider #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input op_t op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input bit repulse);
    int lat;
    int nd;
    logic [31:0] res;
    lat = 0;
    nd  = 0;
    res = '0;
    bus.op       = op;
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.op       = ~op;
    bus.dividend = 32'hDEAD_BEEF;
    bus.divisor  = 32'h0000_0003;
    for (int k = 1; k <= 40; k++) begin
      bus.start = repulse && (k == 5 || k == 20);
      if (bus.done === 1'b1) begin
        nd++;
        if (lat == 0) begin
          lat = k;
          res = bus.result;
        end
      end
      tick();
    end
    bus.start = 1'b0;
    check({tag, "/lat"}, 32'(lat), 32'd33);
    check({tag, "/res"}, res, exp);
    check({tag, "/ndone"}, 32'(nd), 32'd1);
    check({tag, "/held"}, bus.result, exp);
  endtask

  initial begin : stim
    int nd;
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.flush    = 1'b0;
    bus.op       = OP_DIV;
    bus.dividend = '0;
    bus.divisor  = '0;
    tick();
    tick();
    check("rst/busy", 32'(bus.busy), 32'd0);
    check("rst/done", 32'(bus.done), 32'd0);
    check("rst/result", bus.result, 32'd0);
    rst = 1'b0;
    tick();

    run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
    run_op("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0);
    run_op("div_n7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFD, 1'b0);
    run_op("rem_n7_2", OP_REM, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 1'b0);
    run_op("rem_7_n2", OP_REM, 32'd7, 32'hFFFF_FFFE,
           32'd1, 1'b0);
    run_op("div_5_0", OP_DIV, 32'd5, 32'd0,
           32'hFFFF_FFFF, 1'b0);
    run_op("div_n5_0", OP_DIV, 32'hFFFF_FFFB, 32'd0,
           32'hFFFF_FFFF, 1'b0);
    run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, 1'b0);
    run_op("rem_n5_0", OP_REM, 32'hFFFF_FFFB, 32'd0,
           32'hFFFF_FFFB, 1'b0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 1'b0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 1'b0);
    run_op("divu_max", OP_DIVU, 32'hFFFF_FFFF, 32'd1,
           32'hFFFF_FFFF, 1'b0);

    // Re-pulsed start while busy must be dropped.
    run_op("repulse", OP_DIVU, 32'd1000, 32'd9, 32'd111, 1'b1);

    // flush and start together in IDLE: nothing accepted.
    bus.op       = OP_DIVU;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    bus.start    = 1'b1;
    bus.flush    = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("fl_start/busy", 32'(bus.busy), 32'd0);
    tick();
    check("fl_start/done", 32'(bus.done), 32'd0);
    check("fl_start/result", bus.result, 32'd111);

    // Flush at cycle 10 of an op.
    nd = 0;
    bus.op       = OP_DIV;
    bus.dividend = 32'hFFFF_FFF9;
    bus.divisor  = 32'd2;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      if (bus.done === 1'b1) nd++;
      tick();
    end
    check("flush/busy10", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush/busy11", 32'(bus.busy), 32'd0);
    check("flush/done11", 32'(bus.done), 32'd0);
    check("flush/result", bus.result, 32'd111);
    check("flush/nodone", 32'(nd), 32'd0);
    tick();
    run_op("after_flush", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0);

    // Reset at cycle 15 of an op.
    bus.op       = OP_DIVU;
    bus.dividend = 32'd77;
    bus.divisor  = 32'd7;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k < 15; k++) tick();
    rst = 1'b1;
    tick();
    check("rst15/busy", 32'(bus.busy), 32'd0);
    check("rst15/done", 32'(bus.done), 32'd0);
    check("rst15/result", bus.result, 32'd0);
    rst = 1'b0;
    tick();
    run_op("after_rst", OP_DIVU, 32'd77, 32'd7, 32'd11, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
